// File: rtl/token_arbiter_rr_if.sv
// Client-facing bus of the single-token arbiter: per-client handshake codes in,
// grant / ownership / revoke / error status out.
interface token_arbiter_rr_if #(
  parameter int NCLIENT = 4,
  parameter int PW      = $clog2(NCLIENT)
);
  logic [2*NCLIENT-1:0] req_state;
  logic [NCLIENT-1:0]   ack;
  logic [PW-1:0]        owner;
  logic                 busy;
  logic [NCLIENT-1:0]   revoke;
  logic                 err_proto;

  // Clients drive the handshake and watch the status.
  modport master (output req_state, input ack, owner, busy, revoke, err_proto);
  // The arbiter watches the handshake and drives the status.
  modport slave  (input req_state, output ack, owner, busy, revoke, err_proto);
endinterface

// File: rtl/token_arbiter_rr.sv
// Flat single-token arbiter for NCLIENT clients using the four-phase
// idle/request/lock/release handshake. Round-robin or fixed priority,
// bounded hold time with revoke, and a sticky protocol-error flag.
// Every output is decoded from registers only.
module token_arbiter_rr #(
  parameter int NCLIENT   = 4,
  parameter bit FAIR_MODE = 1'b1,
  parameter int MAX_HOLD  = 15,
  localparam int PW = $clog2(NCLIENT),
  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
  input logic               clk,
  input logic               rst_n,
  token_arbiter_rr_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_LOCKED} state_t;
  typedef enum logic [1:0] {
    HS_IDLE = 2'd0,
    HS_REQ  = 2'd1,
    HS_LOCK = 2'd2,
    HS_REL  = 2'd3
  } hs_t;

  localparam logic [CW-1:0]      HOLD_MAX = CW'(MAX_HOLD);
  localparam logic [NCLIENT-1:0] ONE_HOT0 = NCLIENT'(1);

  state_t             r_state, w_state_nxt;
  logic [PW-1:0]      r_owner, w_owner_nxt;
  logic [PW-1:0]      r_last, w_last_nxt;
  logic [PW-1:0]      w_winner;
  logic [CW-1:0]      r_hold_cnt, w_hold_nxt;
  logic               r_err, w_err_nxt;
  logic               w_found;
  logic               w_stray;
  logic               w_revoke_hit;
  hs_t                w_hs [NCLIENT];
  hs_t                w_own_hs;
  logic [NCLIENT-1:0] w_owner_1h;
  int                 w_idx;

  // Split the handshake bus per client; flag lock/release shown by anyone who does not hold the token.
  always_comb begin
    w_stray = 1'b0;
    for (int i = 0; i < NCLIENT; i++) begin
      w_hs[i] = hs_t'(bus.req_state[2*i +: 2]);
      if ((w_hs[i] == HS_LOCK || w_hs[i] == HS_REL) &&
          !(r_state != ST_IDLE && r_owner == PW'(i)))
        w_stray = 1'b1;
    end
    w_own_hs = w_hs[r_owner];
  end

  // Pick the next owner: first requester after the last owner (with wrap), or lowest index.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int k = 0; k < NCLIENT; k++) begin
      w_idx = FAIR_MODE ? (int'(r_last) + 1 + k) % NCLIENT : k;
      if (!w_found && w_hs[w_idx] == HS_REQ) begin
        w_found  = 1'b1;
        w_winner = PW'(w_idx);
      end
    end
  end

  // Next-state logic for the token state machine and its bookkeeping registers.
  // NOTE: every signal gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_hold_nxt  = r_hold_cnt;
    w_err_nxt   = r_err | w_stray;
    unique case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_GRANT;
          w_owner_nxt = w_winner;
        end
      end
      ST_GRANT: begin
        if (w_own_hs == HS_LOCK) begin
          w_state_nxt = ST_LOCKED;
          w_hold_nxt  = '0;
        end else if (w_own_hs == HS_IDLE) begin
          // Abandoned grant: the round-robin pointer stays where it was.
          w_state_nxt = ST_IDLE;
        end else if (w_own_hs == HS_REL) begin
          w_err_nxt = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (w_own_hs == HS_REL || w_own_hs == HS_IDLE) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = r_owner;
          if (w_own_hs == HS_IDLE) w_err_nxt = 1'b1;
        end else if (r_hold_cnt != HOLD_MAX) begin
          w_hold_nxt = r_hold_cnt + CW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and bookkeeping registers; reset arms client 0 as the first round-robin winner.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_owner    <= '0;
      r_last     <= PW'(NCLIENT - 1);
      r_hold_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_last     <= w_last_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign w_owner_1h   = ONE_HOT0 << r_owner;
  assign w_revoke_hit = (MAX_HOLD > 0) && (r_state == ST_LOCKED) && (r_hold_cnt == HOLD_MAX);

  assign bus.ack       = (r_state == ST_GRANT) ? w_owner_1h : '0;
  assign bus.owner     = r_owner;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.revoke    = w_revoke_hit ? w_owner_1h : '0;
  assign bus.err_proto = r_err;

endmodule

// File: tb/tb_token_arbiter_rr.sv
// Self-checking bench for token_arbiter_rr: directed scenarios plus a randomized
// run of protocol-following clients checked against a behavioural token model.
module tb_token_arbiter_rr;
  localparam int N  = 4;
  localparam int MH = 15;
  localparam logic [1:0] H_IDLE = 2'd0, H_REQ = 2'd1, H_LOCK = 2'd2, H_REL = 2'd3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  token_arbiter_rr_if #(.NCLIENT(N)) fr_if ();
  token_arbiter_rr_if #(.NCLIENT(N)) fx_if ();

  token_arbiter_rr #(.NCLIENT(N), .FAIR_MODE(1'b1), .MAX_HOLD(MH)) dut_fr (
    .clk(clk), .rst_n(rst_n), .bus(fr_if.slave));
  token_arbiter_rr #(.NCLIENT(N), .FAIR_MODE(1'b0), .MAX_HOLD(MH)) dut_fx (
    .clk(clk), .rst_n(rst_n), .bus(fx_if.slave));

  logic [1:0] req_fr [N];
  logic [1:0] req_fx [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      fr_if.req_state[2*i +: 2] = req_fr[i];
      fx_if.req_state[2*i +: 2] = req_fx[i];
    end
  end

  int total = 0;
  int bad   = 0;
  int rr_order [6] = '{0, 1, 2, 3, 0, 1};

  // Behavioural model of the round-robin instance: who holds the token, whether it is locked,
  // how many locked cycles have elapsed, the last completed owner and the sticky error.
  int m_holder;
  bit m_locked;
  int m_lock_cyc;
  int m_last;
  bit m_err;

  task automatic model_reset();
    m_holder = -1; m_locked = 1'b0; m_lock_cyc = 0; m_last = N - 1; m_err = 1'b0;
  endtask

  task automatic model_step();
    int h, best, best_d, d;
    h = m_holder;
    for (int i = 0; i < N; i++)
      if ((req_fr[i] == H_LOCK || req_fr[i] == H_REL) && !(i == h)) m_err = 1'b1;
    if (h < 0) begin
      best = -1; best_d = N;
      for (int i = 0; i < N; i++) begin
        d = (i - m_last - 1 + 2 * N) % N;  // distance after the last owner
        if (req_fr[i] == H_REQ && d < best_d) begin best = i; best_d = d; end
      end
      if (best >= 0) begin m_holder = best; m_locked = 1'b0; end
    end else if (!m_locked) begin
      if (req_fr[h] == H_LOCK) begin m_locked = 1'b1; m_lock_cyc = 1; end
      else if (req_fr[h] == H_IDLE) m_holder = -1;
      else if (req_fr[h] == H_REL) m_err = 1'b1;
    end else begin
      if (req_fr[h] == H_REL || req_fr[h] == H_IDLE) begin
        if (req_fr[h] == H_IDLE) m_err = 1'b1;
        m_last = h; m_holder = -1; m_locked = 1'b0;
      end else begin
        m_lock_cyc++;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit fx, input int i, input logic [1:0] v);
    if (fx) req_fx[i] = v;
    else    req_fr[i] = v;
  endtask

  task automatic all_req(input bit fx, input logic [1:0] v);
    for (int i = 0; i < N; i++) set_req(fx, i, v);
  endtask

  task automatic do_reset();
    all_req(1'b0, H_IDLE);
    all_req(1'b1, H_IDLE);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic wait_grant(input bit fx, output int who);
    logic [N-1:0] a;
    who = -1;
    for (int t = 0; t < 8 && who < 0; t++) begin
      tick();
      a = fx ? fx_if.ack : fr_if.ack;
      if (a != '0) who = fx ? int'(fx_if.owner) : int'(fr_if.owner);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (fr_if.ack !== 4'b0000) begin bad++; $display("FAIL reset_ack: got %b want 0000", fr_if.ack); end
    total++; if (fr_if.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", fr_if.busy); end
    total++; if (fr_if.owner !== 2'd0) begin bad++; $display("FAIL reset_owner: got %0d want 0", fr_if.owner); end
    total++; if (fr_if.revoke !== 4'b0000) begin bad++; $display("FAIL reset_revoke: got %b want 0000", fr_if.revoke); end
    total++; if (fr_if.err_proto !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", fr_if.err_proto); end
    total++; if (fx_if.busy !== 1'b0) begin bad++; $display("FAIL reset_fx_busy: got %b want 0", fx_if.busy); end
  endtask

  task automatic test_single_grant();
    do_reset();
    set_req(0, 2, H_REQ); tick();
    total++; if (fr_if.ack !== 4'b0100) begin bad++; $display("FAIL grant_ack: got %b want 0100", fr_if.ack); end
    total++; if (fr_if.owner !== 2'd2) begin bad++; $display("FAIL grant_owner: got %0d want 2", fr_if.owner); end
    total++; if (fr_if.busy !== 1'b1) begin bad++; $display("FAIL grant_busy: got %b want 1", fr_if.busy); end
    set_req(0, 2, H_LOCK); tick();
    total++; if (fr_if.ack !== 4'b0000) begin bad++; $display("FAIL lock_ack: got %b want 0000", fr_if.ack); end
    total++; if (fr_if.busy !== 1'b1) begin bad++; $display("FAIL lock_busy: got %b want 1", fr_if.busy); end
    set_req(0, 2, H_REL); tick();
    total++; if (fr_if.busy !== 1'b0) begin bad++; $display("FAIL release_busy: got %b want 0", fr_if.busy); end
    total++; if (fr_if.err_proto !== 1'b0) begin bad++; $display("FAIL release_err: got %b want 0", fr_if.err_proto); end
    all_req(0, H_REQ); tick();
    total++; if (fr_if.owner !== 2'd3) begin bad++; $display("FAIL after_last2_owner: got %0d want 3", fr_if.owner); end
    total++; if (fr_if.ack !== 4'b1000) begin bad++; $display("FAIL after_last2_ack: got %b want 1000", fr_if.ack); end
    all_req(0, H_IDLE); tick();
  endtask

  task automatic test_round_robin();
    int who, exp;
    for (int sel = 0; sel < 2; sel++) begin
      do_reset();
      all_req(sel[0], H_REQ);
      for (int g = 0; g < 6; g++) begin
        wait_grant(sel[0], who);
        exp = (sel == 1) ? 0 : rr_order[g];
        total++;
        if (who !== exp) begin bad++; $display("FAIL order_mode%0d_grant%0d: got %0d want %0d", 1 - sel, g, who, exp); end
        if (who >= 0) begin
          set_req(sel[0], who, H_LOCK); tick();
          set_req(sel[0], who, H_REL);  tick();
          set_req(sel[0], who, H_REQ);
        end
      end
      all_req(sel[0], H_IDLE); tick(); tick();
    end
  endtask

  task automatic test_revoke();
    logic [N-1:0] exp;
    do_reset();
    set_req(0, 1, H_REQ);  tick();
    set_req(0, 1, H_LOCK); tick();
    for (int c = 1; c <= 20; c++) begin
      exp = (c >= 16) ? 4'b0010 : 4'b0000;
      total++; if (fr_if.revoke !== exp) begin bad++; $display("FAIL revoke_cycle%0d: got %b want %b", c, fr_if.revoke, exp); end
      if (c < 20) tick();
    end
    set_req(0, 1, H_REL); tick();
    total++; if (fr_if.revoke !== 4'b0000) begin bad++; $display("FAIL revoke_cleared: got %b want 0000", fr_if.revoke); end
    total++; if (fr_if.busy !== 1'b0) begin bad++; $display("FAIL revoke_release_busy: got %b want 0", fr_if.busy); end
    total++; if (fr_if.err_proto !== 1'b0) begin bad++; $display("FAIL revoke_err: got %b want 0", fr_if.err_proto); end
    set_req(0, 1, H_IDLE); tick();
  endtask

  task automatic test_abandon();
    do_reset();
    set_req(0, 1, H_REQ);  tick();
    set_req(0, 1, H_LOCK); tick();
    set_req(0, 1, H_REL);  tick();
    set_req(0, 1, H_IDLE); set_req(0, 3, H_REQ); tick();
    total++; if (fr_if.ack !== 4'b1000) begin bad++; $display("FAIL abandon_grant: got %b want 1000", fr_if.ack); end
    set_req(0, 3, H_IDLE); tick();
    total++; if (fr_if.busy !== 1'b0) begin bad++; $display("FAIL abandon_busy: got %b want 0", fr_if.busy); end
    set_req(0, 0, H_REQ); set_req(0, 2, H_REQ); set_req(0, 3, H_REQ); tick();
    total++; if (fr_if.owner !== 2'd2) begin bad++; $display("FAIL abandon_next_owner: got %0d want 2", fr_if.owner); end
    total++; if (fr_if.err_proto !== 1'b0) begin bad++; $display("FAIL abandon_err: got %b want 0", fr_if.err_proto); end
    all_req(0, H_IDLE); tick();
  endtask

  task automatic test_proto_err();
    do_reset();
    set_req(0, 0, H_REQ); tick();
    set_req(0, 0, H_REL); tick();
    total++; if (fr_if.err_proto !== 1'b1) begin bad++; $display("FAIL grant_release_err: got %b want 1", fr_if.err_proto); end
    total++; if (fr_if.ack !== 4'b0001) begin bad++; $display("FAIL grant_release_stays: got %b want 0001", fr_if.ack); end
    do_reset();
    set_req(0, 0, H_REQ);  tick();
    set_req(0, 0, H_LOCK); tick();
    total++; if (fr_if.err_proto !== 1'b0) begin bad++; $display("FAIL clean_lock_err: got %b want 0", fr_if.err_proto); end
    set_req(0, 2, H_LOCK); tick();
    total++; if (fr_if.err_proto !== 1'b1) begin bad++; $display("FAIL stray_lock_err: got %b want 1", fr_if.err_proto); end
    set_req(0, 2, H_IDLE); tick();
    total++; if (fr_if.err_proto !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", fr_if.err_proto); end
    total++; if (fr_if.busy !== 1'b1) begin bad++; $display("FAIL stray_owner_kept: got %b want 1", fr_if.busy); end
    set_req(0, 0, H_REL); tick();
    total++; if (fr_if.busy !== 1'b0) begin bad++; $display("FAIL stray_release_busy: got %b want 0", fr_if.busy); end
    set_req(0, 0, H_IDLE); tick();
    total++; if (fr_if.err_proto !== 1'b1) begin bad++; $display("FAIL err_sticky_idle: got %b want 1", fr_if.err_proto); end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_req(0, 1, H_REQ);  tick();
    set_req(0, 1, H_LOCK); tick();
    repeat (16) tick();
    set_req(0, 2, H_LOCK); tick();
    set_req(0, 2, H_IDLE);
    total++; if (fr_if.revoke !== 4'b0010) begin bad++; $display("FAIL pre_reset_revoke: got %b want 0010", fr_if.revoke); end
    total++; if (fr_if.err_proto !== 1'b1) begin bad++; $display("FAIL pre_reset_err: got %b want 1", fr_if.err_proto); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (fr_if.ack !== 4'b0000) begin bad++; $display("FAIL async_ack: got %b want 0000", fr_if.ack); end
    total++; if (fr_if.busy !== 1'b0) begin bad++; $display("FAIL async_busy: got %b want 0", fr_if.busy); end
    total++; if (fr_if.revoke !== 4'b0000) begin bad++; $display("FAIL async_revoke: got %b want 0000", fr_if.revoke); end
    total++; if (fr_if.err_proto !== 1'b0) begin bad++; $display("FAIL async_err: got %b want 0", fr_if.err_proto); end
    all_req(0, H_IDLE);
    set_req(0, 1, H_REQ); set_req(0, 3, H_REQ);
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    tick();
    total++; if (fr_if.ack !== 4'b0010) begin bad++; $display("FAIL post_reset_ack: got %b want 0010", fr_if.ack); end
    all_req(0, H_IDLE); tick();
  endtask

  task automatic test_random();
    int ph [N];
    int hold [N];
    int r;
    logic [N-1:0] one, e_ack, e_rev;
    logic e_busy;
    one = 1;
    do_reset();
    for (int i = 0; i < N; i++) begin ph[i] = 0; hold[i] = 0; end
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N; i++) req_fr[i] = 2'(ph[i]);
      tick();
      e_busy = (m_holder >= 0);
      e_ack  = (e_busy && !m_locked) ? (one << m_holder) : '0;
      e_rev  = (e_busy && m_locked && m_lock_cyc > MH) ? (one << m_holder) : '0;
      total++; if (fr_if.busy !== e_busy) begin bad++; $display("FAIL rnd_busy@%0d: got %b want %b", cyc, fr_if.busy, e_busy); end
      total++; if (fr_if.ack !== e_ack) begin bad++; $display("FAIL rnd_ack@%0d: got %b want %b", cyc, fr_if.ack, e_ack); end
      total++; if (fr_if.revoke !== e_rev) begin bad++; $display("FAIL rnd_revoke@%0d: got %b want %b", cyc, fr_if.revoke, e_rev); end
      total++; if (fr_if.err_proto !== m_err) begin bad++; $display("FAIL rnd_err@%0d: got %b want %b", cyc, fr_if.err_proto, m_err); end
      if (e_busy) begin
        total++; if (int'(fr_if.owner) !== m_holder) begin bad++; $display("FAIL rnd_owner@%0d: got %0d want %0d", cyc, fr_if.owner, m_holder); end
      end
      for (int i = 0; i < N; i++) begin
        case (ph[i])
          0: if ($urandom_range(3) == 0) ph[i] = 1;
          1: if (fr_if.ack[i]) begin
               r = int'($urandom_range(7));
               if (r == 0) ph[i] = 0;
               else if (r >= 3) begin ph[i] = 2; hold[i] = int'($urandom_range(25)); end
             end
          2: if (hold[i] == 0 || fr_if.revoke[i]) ph[i] = 3; else hold[i]--;
          default: ph[i] = 0;
        endcase
      end
    end
    all_req(0, H_IDLE); tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_grant();
    test_round_robin();
    test_revoke();
    test_abandon();
    test_proto_err();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
